// File: rtl/seg_scan_decoder_pkg.sv
// Shared definitions for the multiplexed 7-segment scan decoder.
// Holds the FSM state type, the active-low segment constants and the
// 16-entry hex decode table so display drivers can reuse the same encoding.
// Segment bit order: bit6=a, bit5=b, ..., bit0=g; 0 lights a segment.
package seg_scan_decoder_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HELD   = 2'd2
  } state_t;

  // Single-segment active-low masks (only the named segment driven low).
  localparam logic [6:0] SEG_A_N     = 7'b0111111;
  localparam logic [6:0] SEG_B_N     = 7'b1011111;
  localparam logic [6:0] SEG_C_N     = 7'b1101111;
  localparam logic [6:0] SEG_D_N     = 7'b1110111;
  localparam logic [6:0] SEG_E_N     = 7'b1111011;
  localparam logic [6:0] SEG_F_N     = 7'b1111101;
  localparam logic [6:0] SEG_G_N     = 7'b1111110;
  localparam logic [6:0] SEG_BLANK_N = 7'b1111111;

  // Active-low glyphs for 0-9, A, b, C, d, E, F; index equals hex value.
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  // True when exactly one active-low digit enable is asserted.
  function automatic logic onehot_low(input logic [3:0] an);
    return $onehot(~an);
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational 7-segment pattern to hex value lookup.
// Ports:
//   seg_n  - active-low segment pattern (bit6=a .. bit0=g)
//   value  - decoded hex value (0 when illegal)
//   legal  - 1 when seg_n matches an entry of the decode table
module seg7_decode
  import seg_scan_decoder_pkg::*;
(
  input  logic [6:0] seg_n,
  output logic [3:0] value,
  output logic       legal
);

  always_comb begin
    value = '0;
    legal = 1'b0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (seg_n == SEG_TABLE[i]) begin
        value = 4'(i);
        legal = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Passive monitor for a 4-digit multiplexed 7-segment display.
// Synchronizes the scan lines, waits for each digit pattern to be stable
// for STABLE_CYCLES samples, decodes it and latches it into its slot.
// Slots not refreshed for STALE_CYCLES cycles are marked invalid.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   seg_n       - monitored segment lines, active-low (bit6=a .. bit0=g)
//   an_n        - monitored digit enables, active-low (bit i = digit i)
//   digits      - captured hex values, nibble i = digit i
//   valid_mask  - bit i set while slot i holds a fresh legal capture
//   upd/upd_idx - one-cycle pulse and slot index of each legal capture
//   code_err    - one-cycle pulse when a stable pattern is not decodable
module seg_scan_decoder
  import seg_scan_decoder_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned STALE_CYCLES  = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  seg_n,
  input  logic [3:0]  an_n,
  output logic [15:0] digits,
  output logic [3:0]  valid_mask,
  output logic        upd,
  output logic [1:0]  upd_idx,
  output logic        code_err
);

  localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned SW = $clog2(STALE_CYCLES + 1);

  logic [6:0]    seg_m, seg_s;
  logic [3:0]    an_m, an_s;
  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [10:0]   pair, pair_nxt, cur;
  logic          cap;
  logic [1:0]    an_idx;
  logic [3:0]    dec_val;
  logic          dec_legal;
  logic [SW-1:0] stale [4];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_m <= '1;
      seg_s <= '1;
      an_m  <= '1;
      an_s  <= '1;
    end else begin
      seg_m <= seg_n;
      seg_s <= seg_m;
      an_m  <= an_n;
      an_s  <= an_m;
    end
  end

  assign cur = {an_s, seg_s};

  always_comb begin
    an_idx = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (!an_s[i]) an_idx = 2'(i);
    end
  end

  // A capture only happens while the current pair equals the recorded one,
  // so the live synchronized segments are what gets decoded.
  seg7_decode u_dec (
    .seg_n (seg_s),
    .value (dec_val),
    .legal (dec_legal)
  );

  // IDLE, a changed pair in SETTLE and a changed pair in HELD all share the
  // same entry rule: start a new dwell if one-hot-low, otherwise go idle.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pair_nxt  = pair;
    cap       = 1'b0;
    if (state == SETTLE && cur == pair) begin
      if (32'(cnt) + 32'd1 >= STABLE_CYCLES) begin
        cap       = 1'b1;
        state_nxt = HELD;
      end else begin
        cnt_nxt = cnt + 1'b1;
      end
    end else if (state == IDLE || cur != pair) begin
      if (onehot_low(an_s)) begin
        state_nxt = SETTLE;
        cnt_nxt   = CW'(1);
        pair_nxt  = cur;
      end else begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      pair  <= '1;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      pair  <= pair_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits     <= '0;
      valid_mask <= '0;
      upd        <= 1'b0;
      upd_idx    <= '0;
      code_err   <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) stale[i] <= '0;
    end else begin
      upd      <= cap & dec_legal;
      code_err <= cap & ~dec_legal;
      if (cap && dec_legal) upd_idx <= an_idx;
      for (int unsigned i = 0; i < 4; i++) begin
        if (cap && dec_legal && an_idx == 2'(i)) begin
          stale[i]         <= '0;
          digits[i*4 +: 4] <= dec_val;
        end else if (stale[i] != SW'(STALE_CYCLES)) begin
          stale[i] <= stale[i] + 1'b1;
        end
        // Capture wins over expiry; expiry clears on the edge the
        // counter reaches STALE_CYCLES.
        if (cap && an_idx == 2'(i)) begin
          valid_mask[i] <= dec_legal;
        end else if (stale[i] >= SW'(STALE_CYCLES - 1)) begin
          valid_mask[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_decoder.sv
module tb_seg_scan_decoder;

  localparam int STABLE = 4;
  localparam int STALE  = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  seg_n = '1;
  logic [3:0]  an_n = '1;
  logic [15:0] digits;
  logic [3:0]  valid_mask;
  logic        upd;
  logic [1:0]  upd_idx;
  logic        code_err;

  seg_scan_decoder #(.STABLE_CYCLES(STABLE), .STALE_CYCLES(STALE)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .seg_n      (seg_n),
    .an_n       (an_n),
    .digits     (digits),
    .valid_mask (valid_mask),
    .upd        (upd),
    .upd_idx    (upd_idx),
    .code_err   (code_err)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;
  int cyc = 0;
  int upd_seen = 0;
  int err_seen = 0;
  int last_upd_cyc = -1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endfunction

  // Glyph list written out independently of the RTL package.
  logic [6:0] glyph [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  // ---------------- behavioural model ----------------
  // The DUT acts on the raw pair seen two edges earlier; a digit is
  // captured on the edge where that delayed pair has been one-hot-low and
  // identical for exactly STABLE consecutive edges.
  logic [10:0] h1 = '1, h2 = '1, prev = '1;
  int          run = 0;
  logic [3:0]  m_dig [4] = '{4'h0, 4'h0, 4'h0, 4'h0};
  int          age [4] = '{0, 0, 0, 0};
  bit          ok [4] = '{0, 0, 0, 0};
  bit          m_upd = 0, m_err = 0;
  logic [1:0]  m_idx = '0;

  always @(posedge clk or negedge rst_n) begin : model
    logic [10:0] p;
    int zeros, slot, v;
    bit legal;
    if (!rst_n) begin
      h1 = '1; h2 = '1; prev = '1; run = 0;
      m_upd = 0; m_err = 0; m_idx = '0;
      for (int i = 0; i < 4; i++) begin m_dig[i] = 4'h0; age[i] = 0; ok[i] = 0; end
    end else begin
      p = h2; h2 = h1; h1 = {an_n, seg_n};
      if (p == prev) run++; else run = 1;
      prev = p;
      m_upd = 0; m_err = 0;
      for (int i = 0; i < 4; i++) if (age[i] < STALE) age[i]++;
      zeros = 0; slot = 0;
      for (int i = 0; i < 4; i++) if (!p[7+i]) begin zeros++; slot = i; end
      if (zeros == 1 && run == STABLE) begin
        legal = 0; v = 0;
        for (int g = 0; g < 16; g++) if (glyph[g] == p[6:0]) begin legal = 1; v = g; end
        if (legal) begin
          m_dig[slot] = 4'(v); ok[slot] = 1; age[slot] = 0;
          m_upd = 1; m_idx = 2'(slot);
        end else begin
          ok[slot] = 0; m_err = 1;
        end
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin : compare
    logic [3:0] mv;
    cyc++;
    for (int i = 0; i < 4; i++) mv[i] = ok[i] && (age[i] < STALE);
    chk("digits", 32'(digits), 32'({m_dig[3], m_dig[2], m_dig[1], m_dig[0]}));
    chk("valid_mask", 32'(valid_mask), 32'(mv));
    chk("upd", 32'(upd), 32'(m_upd));
    chk("code_err", 32'(code_err), 32'(m_err));
    if (m_upd) chk("upd_idx", 32'(upd_idx), 32'(m_idx));
    if (upd && code_err) begin
      nchk++; nerr++;
      $display("FAIL upd_and_code_err at cycle %0d: both high, expected exclusive", cyc);
    end
    if (upd) begin upd_seen++; last_upd_cyc = cyc; end
    if (code_err) err_seen++;
  end

  task automatic drive(input logic [3:0] a, input logic [6:0] s, input int n);
    an_n = a; seg_n = s;
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic clear_seen();
    upd_seen = 0; err_seen = 0; last_upd_cyc = -1;
  endtask

  initial begin
    int t0;
    repeat (3) begin @(negedge clk); #1; end
    chk("rst_digits", 32'(digits), 32'h0);
    chk("rst_valid", 32'(valid_mask), 32'h0);
    chk("rst_upd", 32'(upd), 32'h0);
    rst_n = 1'b1;
    drive(4'b1111, 7'b1111111, 3);

    // Single digit 3 on slot 0
    clear_seen(); t0 = cyc;
    drive(4'b1110, 7'b0000110, 10);
    chk("t1_upd_count", 32'(upd_seen), 32'd1);
    chk("t1_latency", 32'(last_upd_cyc - t0), 32'd6);
    chk("t1_idx", 32'(upd_idx), 32'd0);
    chk("t1_digit0", 32'(digits[3:0]), 32'h3);
    chk("t1_valid", 32'(valid_mask), 32'b0001);

    // Full scan 1,2,3,0
    drive(4'b0111, 7'b1001111, 8);
    drive(4'b1011, 7'b0010010, 8);
    drive(4'b1101, 7'b0000110, 8);
    drive(4'b1110, 7'b0000001, 8);
    chk("t2_digits", 32'(digits), 32'h1230);
    chk("t2_valid", 32'(valid_mask), 32'hF);

    // Illegal pattern on slot 1
    clear_seen();
    drive(4'b1101, 7'b1111110, 10);
    chk("t3_err_count", 32'(err_seen), 32'd1);
    chk("t3_upd_count", 32'(upd_seen), 32'd0);
    chk("t3_valid1", 32'(valid_mask[1]), 32'd0);
    chk("t3_digit1", 32'(digits[7:4]), 32'h3);

    // Pattern toggling faster than the dwell, then two enables low
    clear_seen();
    for (int k = 0; k < 8; k++) drive(4'b1110, (k % 2) ? 7'b0010010 : 7'b1001111, 3);
    drive(4'b1100, 7'b0000110, 10);
    chk("t4_upd_count", 32'(upd_seen), 32'd0);
    chk("t4_err_count", 32'(err_seen), 32'd0);

    // Capture A on slot 2, then let it go stale
    drive(4'b1011, 7'b0001000, 8);
    chk("t5_valid2_fresh", 32'(valid_mask[2]), 32'd1);
    chk("t5_digit2", 32'(digits[11:8]), 32'hA);
    drive(4'b1111, 7'b1111111, 1024);
    chk("t5_valid2_stale", 32'(valid_mask[2]), 32'd0);
    chk("t5_digit2_kept", 32'(digits[11:8]), 32'hA);

    // Reset pulse during the third SETTLE cycle
    clear_seen(); t0 = cyc;
    drive(4'b0111, 7'b0111000, 5);
    rst_n = 1'b0;
    @(negedge clk); #1;
    chk("t6_rst_digits", 32'(digits), 32'h0);
    chk("t6_rst_valid", 32'(valid_mask), 32'h0);
    chk("t6_rst_upd", 32'(upd), 32'h0);
    chk("t6_rst_idx", 32'(upd_idx), 32'h0);
    chk("t6_rst_err", 32'(code_err), 32'h0);
    chk("t6_no_early_upd", 32'(upd_seen), 32'd0);
    rst_n = 1'b1; t0 = cyc;
    drive(4'b0111, 7'b0111000, 10);
    chk("t6_upd_count", 32'(upd_seen), 32'd1);
    chk("t6_latency", 32'(last_upd_cyc - t0), 32'(STABLE + 2));
    chk("t6_digits", 32'(digits), 32'hF000);
    chk("t6_valid", 32'(valid_mask), 32'b1000);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
